// File: rtl/servant_wb_arbiter.sv
// Round-robin Wishbone classic arbiter sharing one slave between N masters,
// with a per-transaction ack watchdog that returns an error to a stalled owner.
module servant_wb_arbiter #(
  parameter int N       = 3,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              wb_clk,
  input  logic              wb_rst_n,
  input  logic [N-1:0]      i_m_cyc,
  input  logic [N-1:0]      i_m_stb,
  input  logic [N-1:0]      i_m_we,
  input  logic [N*AW-1:0]   i_m_adr,
  input  logic [N*DW-1:0]   i_m_dat,
  input  logic [N*DW/8-1:0] i_m_sel,
  output logic [DW-1:0]     o_m_rdt,
  output logic [N-1:0]      o_m_ack,
  output logic [N-1:0]      o_m_err,
  output logic              o_s_cyc,
  output logic              o_s_stb,
  output logic              o_s_we,
  output logic [AW-1:0]     o_s_adr,
  output logic [DW-1:0]     o_s_dat,
  output logic [DW/8-1:0]   o_s_sel,
  input  logic [DW-1:0]     i_s_rdt,
  input  logic              i_s_ack,
  output logic [N-1:0]      o_grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int SW = DW / 8;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] owner_q, owner_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  err_q, err_d;

  logic          req_found;
  logic [PW-1:0] req_pick;
  logic [PW-1:0] scan_idx;
  logic          own_cyc;
  logic          timeout_hit;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] o);
    if (int'(o) == N - 1) return '0;
    else                  return o + PW'(1);
  endfunction

  // First requester at or after the priority pointer, wrapping mod N.
  always_comb begin
    req_found = 1'b0;
    req_pick  = ptr_q;
    scan_idx  = '0;
    for (int i = 0; i < N; i++) begin
      scan_idx = PW'((int'(ptr_q) + i) % N);
      if (!req_found && i_m_cyc[scan_idx]) begin
        req_found = 1'b1;
        req_pick  = scan_idx;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    err_d       = '0;
    own_cyc     = 1'b0;
    timeout_hit = 1'b0;
    o_grant     = '0;
    o_m_ack     = '0;
    o_s_cyc     = 1'b0;
    o_s_stb     = 1'b0;
    o_s_we      = 1'b0;
    o_s_adr     = '0;
    o_s_dat     = '0;
    o_s_sel     = '0;
    case (state_q)
      IDLE: begin
        if (req_found) begin
          state_d = BUSY;
          owner_d = req_pick;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        own_cyc     = i_m_cyc[owner_q];
        // An ack arriving on the expiry cycle still completes normally.
        timeout_hit = (TIMEOUT > 0) && (cnt_q == CW'(TIMEOUT)) && !i_s_ack;
        o_grant[owner_q] = 1'b1;
        o_s_cyc = own_cyc & ~timeout_hit;
        o_s_stb = i_m_stb[owner_q] & ~timeout_hit;
        o_s_we  = i_m_we[owner_q];
        o_s_adr = i_m_adr[int'(owner_q)*AW +: AW];
        o_s_dat = i_m_dat[int'(owner_q)*DW +: DW];
        o_s_sel = i_m_sel[int'(owner_q)*SW +: SW];
        o_m_ack[owner_q] = i_s_ack & own_cyc;
        if (!own_cyc || i_s_ack || timeout_hit) begin
          state_d = IDLE;
          ptr_d   = next_ptr(owner_q);
          cnt_d   = '0;
          if (own_cyc && timeout_hit) err_d[owner_q] = 1'b1;
        end else if (TIMEOUT > 0) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign o_m_err = err_q;
  assign o_m_rdt = i_s_rdt;

endmodule

// File: tb/tb_servant_wb_arbiter.sv
// Scoreboard bench for servant_wb_arbiter: directed transactions push expected
// grants/responses; a negedge monitor pops and compares as the DUT presents them.
module tb_servant_wb_arbiter;
  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 4;
  localparam logic [31:0] RK = 32'h5A5A_0000;

  logic              wb_clk = 1'b0;
  logic              wb_rst_n = 1'b0;
  logic [N-1:0]      i_m_cyc = '0;
  logic [N-1:0]      i_m_stb = '0;
  logic [N-1:0]      i_m_we = '0;
  logic [N*AW-1:0]   i_m_adr = '0;
  logic [N*DW-1:0]   i_m_dat = '0;
  logic [N*SW-1:0]   i_m_sel = '0;
  logic [DW-1:0]     o_m_rdt;
  logic [N-1:0]      o_m_ack;
  logic [N-1:0]      o_m_err;
  logic              o_s_cyc;
  logic              o_s_stb;
  logic              o_s_we;
  logic [AW-1:0]     o_s_adr;
  logic [DW-1:0]     o_s_dat;
  logic [SW-1:0]     o_s_sel;
  logic [DW-1:0]     i_s_rdt = '0;
  logic              i_s_ack = 1'b0;
  logic [N-1:0]      o_grant;

  servant_wb_arbiter #(.N(N), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .wb_clk(wb_clk), .wb_rst_n(wb_rst_n),
    .i_m_cyc(i_m_cyc), .i_m_stb(i_m_stb), .i_m_we(i_m_we),
    .i_m_adr(i_m_adr), .i_m_dat(i_m_dat), .i_m_sel(i_m_sel),
    .o_m_rdt(o_m_rdt), .o_m_ack(o_m_ack), .o_m_err(o_m_err),
    .o_s_cyc(o_s_cyc), .o_s_stb(o_s_stb), .o_s_we(o_s_we),
    .o_s_adr(o_s_adr), .o_s_dat(o_s_dat), .o_s_sel(o_s_sel),
    .i_s_rdt(i_s_rdt), .i_s_ack(i_s_ack), .o_grant(o_grant)
  );

  always #5 wb_clk = ~wb_clk;

  typedef struct packed {
    logic [2:0]  ack;
    logic [2:0]  err;
    logic [31:0] rdt;
  } resp_t;

  int    exp_g[$];
  resp_t exp_r[$];
  int    n_chk = 0;
  int    n_pass = 0;

  int          slv_lat = 0;
  logic        slv_fixed = 1'b0;
  logic [31:0] slv_rdt = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
  endtask

  task automatic expect_txn(input int k, input logic [2:0] ack, input logic [2:0] err,
                            input logic [31:0] rdt);
    resp_t r;
    r.ack = ack;
    r.err = err;
    r.rdt = rdt;
    exp_g.push_back(k);
    exp_r.push_back(r);
  endtask

  task automatic set_master(input int k, input logic we, input logic [31:0] adr,
                            input logic [31:0] dat, input logic [3:0] sel);
    i_m_cyc[k] = 1'b1;
    i_m_stb[k] = 1'b1;
    i_m_we[k]  = we;
    i_m_adr[k*AW +: AW] = adr;
    i_m_dat[k*DW +: DW] = dat;
    i_m_sel[k*SW +: SW] = sel;
  endtask

  task automatic drop(input int k);
    i_m_cyc[k] = 1'b0;
    i_m_stb[k] = 1'b0;
  endtask

  // Wait for ack or err on master k, then release its request after that edge.
  task automatic wait_resp(input int k, input int bound);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < bound && !seen; c++) begin
      @(negedge wb_clk);
      if (o_m_ack[k] || o_m_err[k]) seen = 1'b1;
    end
    if (!seen) begin
      n_chk++;
      $display("FAIL wait_resp%0d: got no response want ack/err within %0d cycles", k, bound);
    end
    @(posedge wb_clk); #1;
    drop(k);
  endtask

  // Slave: acks after slv_lat wait cycles of an active grant; negative = never.
  initial begin
    int wcnt;
    wcnt = 0;
    forever begin
      @(posedge wb_clk); #1;
      i_s_ack = 1'b0;
      if (o_grant != '0) begin
        if (slv_lat >= 0 && wcnt == slv_lat) begin
          i_s_ack = 1'b1;
          i_s_rdt = slv_fixed ? slv_rdt : (o_s_adr ^ RK);
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // Monitor: new grants and ack/err responses are popped from the scoreboard.
  initial begin
    logic [2:0] prev_g;
    resp_t      r;
    int         g;
    prev_g = '0;
    forever begin
      @(negedge wb_clk);
      if (o_grant != '0 && o_grant != prev_g) begin
        chk("idle_gap", {29'b0, prev_g}, 32'd0);
        if (exp_g.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_grant: got %b want none", o_grant);
        end else begin
          g = exp_g.pop_front();
          chk("grant", {29'b0, o_grant}, 32'(1 << g));
        end
      end
      if (o_m_ack != '0 || o_m_err != '0) begin
        if (exp_r.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_resp: got ack=%b err=%b want none", o_m_ack, o_m_err);
        end else begin
          r = exp_r.pop_front();
          chk("ack", {29'b0, o_m_ack}, {29'b0, r.ack});
          chk("err", {29'b0, o_m_err}, {29'b0, r.err});
          if (r.ack != '0) chk("rdt", o_m_rdt, r.rdt);
        end
      end
      prev_g = o_grant;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish within 20000 cycles");
    $fatal(1, "bench timeout");
  end

  initial begin
    int n;
    // Reset state
    repeat (3) @(negedge wb_clk);
    chk("rst_grant", {29'b0, o_grant}, 32'd0);
    chk("rst_scyc", {31'b0, o_s_cyc}, 32'd0);
    chk("rst_sstb", {31'b0, o_s_stb}, 32'd0);
    chk("rst_ack", {29'b0, o_m_ack}, 32'd0);
    chk("rst_err", {29'b0, o_m_err}, 32'd0);
    chk("rst_sadr", o_s_adr, 32'd0);
    #1 wb_rst_n = 1'b1;

    // Single read from master 1, slave acks after 2 wait cycles
    @(negedge wb_clk); #1;
    slv_lat = 2; slv_fixed = 1'b1; slv_rdt = 32'hDEADBEEF;
    expect_txn(1, 3'b010, 3'b000, 32'hDEADBEEF);
    set_master(1, 1'b0, 32'h100, 32'h0, 4'hF);
    @(negedge wb_clk);
    chk("single_grant", {29'b0, o_grant}, 32'h2);
    chk("single_sadr", o_s_adr, 32'h100);
    chk("single_scyc", {31'b0, o_s_cyc}, 32'd1);
    chk("single_swe", {31'b0, o_s_we}, 32'd0);
    wait_resp(1, 20);
    @(negedge wb_clk);
    chk("single_idle", {29'b0, o_grant}, 32'd0);

    // Simultaneous requests from 0 and 2 straight after reset
    @(negedge wb_clk); #1 wb_rst_n = 1'b0;
    @(negedge wb_clk); #1 wb_rst_n = 1'b1;
    slv_lat = 1; slv_fixed = 1'b0;
    expect_txn(0, 3'b001, 3'b000, 32'h40 ^ RK);
    expect_txn(2, 3'b100, 3'b000, 32'h80 ^ RK);
    set_master(0, 1'b1, 32'h40, 32'h11223344, 4'hC);
    set_master(2, 1'b0, 32'h80, 32'h0, 4'hF);
    @(negedge wb_clk);
    chk("sim_grant", {29'b0, o_grant}, 32'h1);
    chk("sim_swe", {31'b0, o_s_we}, 32'd1);
    chk("sim_sdat", o_s_dat, 32'h11223344);
    chk("sim_ssel", {28'b0, o_s_sel}, 32'hC);
    wait_resp(0, 20);
    wait_resp(2, 20);

    // Fairness: all masters request continuously, 1-cycle slave
    slv_lat = 0;
    for (int t = 0; t < 30; t++)
      expect_txn(t % 3, 3'(1 << (t % 3)), 3'b000, (32'h200 + 32'(4 * (t % 3))) ^ RK);
    for (int k = 0; k < 3; k++) set_master(k, 1'b0, 32'h200 + 32'(4 * k), 32'h0, 4'hF);
    n = 0;
    for (int c = 0; c < 120 && n < 30; c++) begin
      @(negedge wb_clk);
      if (o_m_ack != '0) n++;
    end
    chk("fair_count", n, 32'd30);
    @(posedge wb_clk); #1;
    for (int k = 0; k < 3; k++) drop(k);
    @(negedge wb_clk);
    chk("fair_idle", {29'b0, o_grant}, 32'd0);

    // Watchdog: master 2 never acked, master 0 pending behind it
    slv_lat = -1;
    expect_txn(2, 3'b000, 3'b100, 32'h0);
    expect_txn(0, 3'b001, 3'b000, 32'h340 ^ RK);
    set_master(2, 1'b0, 32'h300, 32'h0, 4'hF);
    @(negedge wb_clk);
    chk("to_grant", {29'b0, o_grant}, 32'h4);
    set_master(0, 1'b0, 32'h340, 32'h0, 4'hF);
    repeat (3) @(negedge wb_clk);
    chk("to_scyc_live", {31'b0, o_s_cyc}, 32'd1);
    chk("to_err_early", {29'b0, o_m_err}, 32'd0);
    @(negedge wb_clk);
    chk("to_scyc_forced", {31'b0, o_s_cyc}, 32'd0);
    chk("to_sstb_forced", {31'b0, o_s_stb}, 32'd0);
    @(negedge wb_clk);
    chk("to_err", {29'b0, o_m_err}, 32'h4);
    chk("to_idle", {29'b0, o_grant}, 32'd0);
    slv_lat = 0;
    @(posedge wb_clk); #1;
    drop(2);
    wait_resp(0, 20);

    // Ack on the same cycle the watchdog expires
    slv_lat = TO;
    expect_txn(1, 3'b010, 3'b000, 32'h500 ^ RK);
    set_master(1, 1'b0, 32'h500, 32'h0, 4'hF);
    wait_resp(1, 20);
    @(negedge wb_clk);
    chk("bound_no_err", {29'b0, o_m_err}, 32'd0);
    chk("bound_idle", {29'b0, o_grant}, 32'd0);

    // Abort: owner drops cyc mid-wait
    slv_lat = -1;
    exp_g.push_back(0);
    set_master(0, 1'b0, 32'h600, 32'h0, 4'hF);
    @(negedge wb_clk);
    chk("abort_grant", {29'b0, o_grant}, 32'h1);
    @(negedge wb_clk); #1;
    drop(0);
    #1;
    chk("abort_scyc", {31'b0, o_s_cyc}, 32'd0);
    chk("abort_ack", {29'b0, o_m_ack}, 32'd0);
    @(negedge wb_clk);
    chk("abort_idle", {29'b0, o_grant}, 32'd0);
    repeat (6) @(negedge wb_clk);
    chk("abort_no_err", {29'b0, o_m_err}, 32'd0);

    // Reset asserted while master 2 is busy with 0 and 1 pending
    set_master(2, 1'b0, 32'h700, 32'h0, 4'hF);
    exp_g.push_back(2);
    @(negedge wb_clk);
    chk("rb_grant", {29'b0, o_grant}, 32'h4);
    set_master(0, 1'b0, 32'h740, 32'h0, 4'hF);
    set_master(1, 1'b0, 32'h780, 32'h0, 4'hF);
    @(negedge wb_clk);
    chk("rb_hold", {29'b0, o_grant}, 32'h4);
    #1 wb_rst_n = 1'b0;
    #1;
    chk("rb_grant_clr", {29'b0, o_grant}, 32'd0);
    chk("rb_scyc_clr", {31'b0, o_s_cyc}, 32'd0);
    chk("rb_ack_clr", {29'b0, o_m_ack}, 32'd0);
    expect_txn(0, 3'b001, 3'b000, 32'h740 ^ RK);
    expect_txn(1, 3'b010, 3'b000, 32'h780 ^ RK);
    expect_txn(2, 3'b100, 3'b000, 32'h700 ^ RK);
    slv_lat = 0;
    @(negedge wb_clk); #1 wb_rst_n = 1'b1;
    wait_resp(0, 20);
    wait_resp(1, 20);
    wait_resp(2, 20);

    repeat (5) @(negedge wb_clk);
    chk("grant_q_empty", exp_g.size(), 32'd0);
    chk("resp_q_empty", exp_r.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/servant_wb_arbiter.md
Name: servant_wb_arbiter

Overview:
- Round-robin Wishbone classic arbiter. Shares the servant single-port RAM slave between N requesting masters: serv ibus, serv dbus, and a memory loader/debug port.
- Sits between the masters and the RAM inside the servant SoC top.
- Adds a per-transaction watchdog so a hung slave cannot stall the simulation bench forever.

Parameters:
- N, 3, number of masters; index 0 = ibus, 1 = dbus, 2 = loader.
- AW, 32, address width.
- DW, 32, data width; DW/8 select bits.
- TIMEOUT, 255, max cycles a granted transaction waits for ack before an error is returned; 0 disables the watchdog.

Ports:
- wb_clk  input  1  clock.
- wb_rst_n  input  1  reset; asynchronous, active-low.
- i_m_cyc  input  N  per-master cycle request.
- i_m_stb  input  N  per-master strobe.
- i_m_we  input  N  per-master write enable.
- i_m_adr  input  N*AW  flattened addresses; master k at [k*AW +: AW].
- i_m_dat  input  N*DW  flattened write data.
- i_m_sel  input  N*DW/8  flattened byte selects.
- o_m_rdt  output  DW  read data, broadcast to all masters.
- o_m_ack  output  N  per-master ack.
- o_m_err  output  N  per-master timeout error.
- o_s_cyc  output  1  slave cycle.
- o_s_stb  output  1  slave strobe.
- o_s_we  output  1  slave write enable.
- o_s_adr  output  AW  slave address.
- o_s_dat  output  DW  slave write data.
- o_s_sel  output  DW/8  slave byte select.
- i_s_rdt  input  DW  slave read data.
- i_s_ack  input  1  slave ack.
- o_grant  output  N  one-hot current owner; all zero when idle.

Behaviour:
- State machine IDLE/BUSY.
  - Registered state: owner index, priority pointer ptr (log2 N bits), watchdog counter.
- Reset (async, wb_rst_n low), takes effect immediately:
  - state = IDLE, ptr = 0, counter = 0.
  - o_grant = 0, o_s_cyc = 0, o_s_stb = 0, o_m_ack = 0, o_m_err = 0.
  - o_s_adr/o_s_dat/o_s_sel/o_s_we driven 0 while idle.
- IDLE:
  - If any i_m_cyc bit is set, select the first requester scanning ptr, ptr+1, ... wrapping mod N.
  - On the next edge: state = BUSY, o_grant = one-hot(owner).
  - Arbitration latency: 1 cycle from cyc to grant/slave cyc.
- BUSY, combinational forwarding from the owner:
  - o_s_cyc = i_m_cyc[owner]; o_s_stb = i_m_stb[owner].
  - o_s_we/adr/dat/sel come from the owner's slice.
  - o_m_ack[owner] = i_s_ack; all other acks are 0.
  - o_m_rdt = i_s_rdt unconditionally.
- BUSY exit conditions:
  - On i_s_ack: next state IDLE, ptr = owner+1 mod N, counter cleared.
  - Mandatory one idle cycle between grants; no back-to-back regrant.
  - If the owner drops i_m_cyc before ack (abort): next state IDLE, ptr = owner+1, no ack or err issued.
- Watchdog (TIMEOUT > 0):
  - Counter increments each BUSY cycle without ack.
  - When counter == TIMEOUT with no ack that cycle: o_m_err[owner] pulses 1 cycle (registered), o_s_cyc/stb forced 0 that cycle.
  - Then state IDLE, ptr = owner+1.
  - Ack in the same cycle the counter hits TIMEOUT wins: normal ack, no err.
- Non-owner requests are held pending with no ack; they are never dropped.
- Grant always goes to a master whose cyc is high in the arbitration cycle.
- N=1 degenerates to a passthrough with the 1-cycle grant latency.
- Reset asserted mid-transaction:
  - All outputs clear asynchronously.
  - Any in-flight ack from the slave is ignored.
  - ptr returns to 0.

Test Plan:
- Single request: master 1 raises cyc/stb/we=0 at adr 0x100 → o_grant=3'b010 next edge. o_s_adr=0x100. Slave acks after 2 cycles with rdt 0xDEADBEEF → o_m_ack=3'b010 for 1 cycle, o_m_rdt=0xDEADBEEF. Then 1 IDLE cycle.
- Round-robin fairness: all three masters hold cyc continuously, slave acks every access in 1 cycle → grant sequence 0,1,2,0,1,2. Each grant is separated by exactly one idle cycle; no master is starved over 30 transactions.
- Simultaneous request after reset: masters 0 and 2 request on the same cycle → master 0 is granted first (ptr=0), master 2 next.
- Timeout: TIMEOUT=4, master 2 requests, slave never acks → o_m_err=3'b100 pulses exactly 4 BUSY cycles after grant, o_s_cyc drops, and master 0's pending request is granted next.
- Ack at timeout boundary: ack arrives on the cycle the counter reaches TIMEOUT → o_m_ack asserted, o_m_err stays 0.
- Abort and reset: the owner drops cyc mid-wait → IDLE with no ack/err. Separately, wb_rst_n pulsed low during BUSY → o_grant=0 and o_s_cyc=0 immediately (before the next edge), and the first grant after release goes to the lowest-index requester.
